// File: rtl/fact_pkg.sv
// fact_pkg: shared definitions for the factorial engine.
//   state_t         - engine FSM encoding (IDLE, CALC, DONE, ERR)
//   DEFAULT_WIDTH   - default result/product width in bits
//   DEFAULT_N_WIDTH - default operand width in bits
package fact_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_N_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/fact_dp.sv
// fact_dp: factorial datapath (down-counter, running product, multiplier).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - load cnt <= n_in and prod <= 1
//   step        - prod <= low half of prod*cnt, cnt <= cnt-1
//   n_in        - operand to load
//   prod        - running product
//   last        - cnt <= 1, no further multiply needed
//   ovf         - upper half of prod*cnt is nonzero
module fact_dp
    import fact_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int N_WIDTH = DEFAULT_N_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [N_WIDTH-1:0] n_in,
    output logic [WIDTH-1:0]   prod,
    output logic               last,
    output logic               ovf
);

    logic [N_WIDTH-1:0]   cnt;
    logic [2*WIDTH-1:0]   wide;

    // Full double-width product so overflow is visible in the upper half.
    assign wide = {{WIDTH{1'b0}}, prod} * {{(2*WIDTH-N_WIDTH){1'b0}}, cnt};
    assign ovf  = |wide[2*WIDTH-1:WIDTH];
    assign last = (cnt <= N_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            prod <= '0;
        end else if (load) begin
            cnt  <= n_in;
            prod <= WIDTH'(1);
        end else if (step) begin
            cnt  <= cnt - N_WIDTH'(1);
            prod <= wide[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fact_engine.sv
// fact_engine: iterative factorial engine, one multiply per clock.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   go          - start request, accepted only in IDLE
//   abort       - cancel a calculation in CALC (no done pulse)
//   n_in        - operand, sampled with an accepted go
//   busy        - high whenever the FSM is not in IDLE
//   done        - one-cycle completion pulse (success or error)
//   error       - qualifies done: operand out of range or overflow
//   result      - n_in!, loaded together with done; 0 on error
// Handshake: go is a level sampled on each rising edge while busy=0; an
// accepted go produces exactly one done pulse unless aborted. No queuing.
module fact_engine
    import fact_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int N_WIDTH = DEFAULT_N_WIDTH,
    parameter int MAX_N   = 2**N_WIDTH - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic               abort,
    input  logic [N_WIDTH-1:0] n_in,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [WIDTH-1:0]   result
);

    // One extra bit so MAX_N = 2**N_WIDTH-1 compares without truncation.
    localparam logic [N_WIDTH:0] MAX_N_EXT = (N_WIDTH+1)'(MAX_N);

    state_t           state;
    logic             range_err;
    logic             load;
    logic             step;
    logic [WIDTH-1:0] prod;
    logic             last;
    logic             ovf;

    assign range_err = ({1'b0, n_in} > MAX_N_EXT);
    assign load      = (state == IDLE) && go && !range_err;
    assign step      = (state == CALC) && !abort && !last && !ovf;

    fact_dp #(
        .WIDTH   (WIDTH),
        .N_WIDTH (N_WIDTH)
    ) u_dp (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .n_in  (n_in),
        .prod  (prod),
        .last  (last),
        .ovf   (ovf)
    );

    // busy/done/error are registered alongside state, so they are pure
    // functions of the state register. result is loaded on entry to
    // DONE/ERR so it is already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
            result <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        busy <= 1'b1;
                        if (range_err) begin
                            state  <= ERR;
                            done   <= 1'b1;
                            error  <= 1'b1;
                            result <= '0;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // abort outranks both completion and overflow
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (last) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= prod;
                    end else if (ovf) begin
                        state  <= ERR;
                        done   <= 1'b1;
                        error  <= 1'b1;
                        result <= '0;
                    end
                end
                DONE, ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fact_engine.sv
// tb_fact_engine: directed bench for fact_engine (default instance plus an
// instance with MAX_N=10 for the range-error path).
module tb_fact_engine;

    logic        clk;
    logic        rst_n;
    logic        go, abort, go_r;
    logic [3:0]  n_in, n_r;
    logic        busy, done, error;
    logic        busy_r, done_r, error_r;
    logic [31:0] result, result_r;

    int compared = 0;
    int mismatched = 0;

    fact_engine dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .go     (go),
        .abort  (abort),
        .n_in   (n_in),
        .busy   (busy),
        .done   (done),
        .error  (error),
        .result (result)
    );

    fact_engine #(.WIDTH(32), .N_WIDTH(4), .MAX_N(10)) dut_r (
        .clk    (clk),
        .rst_n  (rst_n),
        .go     (go_r),
        .abort  (1'b0),
        .n_in   (n_r),
        .busy   (busy_r),
        .done   (done_r),
        .error  (error_r),
        .result (result_r)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; one rising edge samples go.
    task automatic start(input logic [3:0] n);
        @(negedge clk);
        go   = 1'b1;
        n_in = n;
        @(negedge clk);
        go   = 1'b0;
    endtask

    task automatic start_r(input logic [3:0] n);
        @(negedge clk);
        go_r = 1'b1;
        n_r  = n;
        @(negedge clk);
        go_r = 1'b0;
    endtask

    // Called on the falling edge after the accepting edge. lat counts
    // rising edges from there to the done pulse; bcnt counts busy cycles
    // seen before done.
    task automatic wait_done(input bit sel, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!(sel ? done_r : done) && lat < 100) begin
            if (sel ? busy_r : busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    int lat, bcnt, dcnt, acnt;
    logic prev_busy;
    bit seen_done;

    initial begin
        rst_n = 1'b0;
        go    = 1'b0;
        abort = 1'b0;
        go_r  = 1'b0;
        n_in  = '0;
        n_r   = '0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy",   busy,   0);
        check("rst_done",   done,   0);
        check("rst_error",  error,  0);
        check("rst_result", result, 0);
        check("rst_cnt",    dut.u_dp.cnt,  0);
        check("rst_prod",   dut.u_dp.prod, 0);

        // first go on the first edge after reset release: 5! = 120
        rst_n = 1'b1;
        go    = 1'b1;
        n_in  = 4'd5;
        @(negedge clk);
        go = 1'b0;
        check("n5_busy_after_go", busy, 1);
        wait_done(0, lat, bcnt);
        check("n5_lat",    lat,    5);
        check("n5_busycnt", bcnt,  5);
        check("n5_error",  error,  0);
        check("n5_result", result, 120);
        @(negedge clk);
        check("n5_done_pulse", done, 0);
        check("n5_idle",       busy, 0);
        check("n5_hold",       result, 120);

        // 0! and 1!
        start(4'd0);
        wait_done(0, lat, bcnt);
        check("n0_lat", lat, 1);
        check("n0_result", result, 1);
        start(4'd1);
        wait_done(0, lat, bcnt);
        check("n1_lat", lat, 1);
        check("n1_result", result, 1);

        // 12! fits in 32 bits
        start(4'd12);
        wait_done(0, lat, bcnt);
        check("n12_lat", lat, 12);
        check("n12_error", error, 0);
        check("n12_result", result, 479001600);

        // 13! overflows on the x2 multiply (12th edge)
        start(4'd13);
        wait_done(0, lat, bcnt);
        check("n13_lat", lat, 12);
        check("n13_error", error, 1);
        check("n13_result", result, 0);

        // range error on the MAX_N=10 instance: done right after accept
        start_r(4'd11);
        check("rng_done",   done_r,   1);
        check("rng_error",  error_r,  1);
        check("rng_result", result_r, 0);
        @(negedge clk);
        check("rng_idle", busy_r, 0);
        start_r(4'd10);
        wait_done(1, lat, bcnt);
        check("r10_lat", lat, 10);
        check("r10_error", error_r, 0);
        check("r10_result", result_r, 3628800);

        // abort in IDLE alongside go has no effect: 4! = 24
        abort = 1'b1;
        start(4'd4);
        abort = 1'b0;
        wait_done(0, lat, bcnt);
        check("n4_result", result, 24);

        // abort in the third CALC cycle of 7!
        start(4'd7);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) seen_done = 1;
            @(negedge clk);
        end
        check("abort_no_done", seen_done, 0);
        check("abort_result_kept", result, 24);
        start(4'd3);
        wait_done(0, lat, bcnt);
        check("n3_lat", lat, 3);
        check("n3_result", result, 6);

        // abort coinciding with completion of 2! wins
        start(4'd2);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_cmp_done", done, 0);
        check("abort_cmp_busy", busy, 0);
        check("abort_cmp_result", result, 6);

        // asynchronous reset mid-CALC
        start(4'd9);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy",   busy,   0);
        check("mid_rst_done",   done,   0);
        check("mid_rst_error",  error,  0);
        check("mid_rst_result", result, 0);
        check("mid_rst_cnt",    dut.u_dp.cnt,  0);
        check("mid_rst_prod",   dut.u_dp.prod, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // go held high through busy: 3! repeats every 5 cycles
        go   = 1'b1;
        n_in = 4'd3;
        dcnt = 0;
        acnt = 0;
        prev_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy && !prev_busy) acnt++;
            if (done) dcnt++;
            prev_busy = busy;
        end
        go = 1'b0;
        check("held_accepts", acnt, 4);
        check("held_dones",   dcnt, 4);
        check("held_result",  result, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fact_engine.md
FACT_ENGINE -- requirements
Module: fact_engine

Interface
REQ-001 Parameter WIDTH, default 32, sets the result and product register width in bits (minimum 8).
REQ-002 Parameter N_WIDTH, default 4, sets the operand width in bits.
REQ-003 Parameter MAX_N, default 2**N_WIDTH-1, is the largest operand accepted without error.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 go  input  1  start request, sampled on each rising edge while idle.
REQ-007 abort  input  1  cancels a calculation in progress.
REQ-008 n_in  input  N_WIDTH  operand, sampled on the same edge go is accepted.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle completion pulse, for both success and error.
REQ-011 error  output  1  qualifies done: range or overflow failure.
REQ-012 result  output  WIDTH  n_in factorial; held stable between completions.

Function
REQ-013 The engine SHALL implement states IDLE, CALC, DONE and ERR, with done and error decoded from state only (no input-to-output path).
REQ-014 IDLE, go=1, n_in>MAX_N: the engine SHALL go to ERR.
REQ-015 IDLE, go=1, n_in<=MAX_N: the engine SHALL load cnt<=n_in and prod<=1, then go to CALC.
REQ-016 go SHALL be ignored while busy=1; no queuing.
REQ-017 CALC, cnt<=1: the engine SHALL go to DONE.
REQ-018 CALC, cnt>1: the engine SHALL compute prod*cnt at 2*WIDTH bits, store the low WIDTH bits in prod and decrement cnt.
REQ-019 If the upper WIDTH bits of that product are nonzero, the engine SHALL go to ERR instead of continuing.
REQ-020 abort=1 in CALC SHALL return the engine to IDLE on the next edge, with no done pulse and result unchanged.
REQ-021 If abort and an overflow or completion occur in the same cycle, abort SHALL take priority.
REQ-022 abort SHALL have no effect in IDLE, DONE or ERR.
REQ-023 DONE: done=1, error=0, result<=prod, then IDLE.
REQ-024 ERR: done=1, error=1, result<=0, then IDLE.
REQ-025 Latency: done SHALL be high in the cycle following edge number max(n_in,1) after the accepting edge.
REQ-026 Latency, range error: done SHALL be high in the cycle following the accepting edge.
REQ-027 Latency, overflow: done SHALL be high in the cycle following the overflowing multiply edge.
REQ-028 A new go SHALL be acceptable on the edge at which IDLE is re-entered, giving back-to-back throughput.
REQ-029 The engine SHALL correctly return 0!=1 and 1!=1.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, error=0, result=0, cnt=0 and prod=0, including mid-calculation.
REQ-031 The first go SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-032 Package fact_pkg SHALL hold the state typedef (IDLE, CALC, DONE, ERR) and the WIDTH and N_WIDTH defaults.
REQ-033 Sub-module fact_dp SHALL hold cnt, prod, the 2*WIDTH multiplier and overflow flag.
REQ-034 fact_engine SHALL hold only the FSM and the result register.

Verification
REQ-035 WIDTH=32, go with n_in=5 -> done after 5 edges, error=0, result=120, busy high for 5 cycles.
REQ-036 n_in=0 and n_in=1 -> done after 1 edge, result=1.
REQ-037 WIDTH=32, n_in=13 -> overflow, done=1 and error=1, result=0; n_in=12 -> result=479001600.
REQ-038 MAX_N=10, n_in=11 -> done=1 and error=1 one edge after go, no CALC cycle.
REQ-039 n_in=7, abort in the third CALC cycle -> IDLE with no done and previous result kept; then go with n_in=3 -> result=6.
REQ-040 rst_n pulsed low mid-CALC -> all outputs 0 asynchronously; a go held high through busy -> exactly one completion per acceptance.
